// File: rtl/series_pkg.sv
// Shared definitions for the series-evaluation sequencer: controller state
// encoding, Q4.11 fixed-point constants and a small zero-test helper.
package series_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 11;
  localparam logic [DATA_W-1:0] ONE_Q = 16'h0800;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    MUL_REQ   = 3'd2,
    LOAD_TERM = 3'd3,
    ACCUM     = 3'd4,
    DONE      = 3'd5
  } state_t;

  // True when a fixed-point value has underflowed to exactly zero.
  function automatic logic is_zero_q(input logic [DATA_W-1:0] value);
    return (value == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/ack_timeout_cnt.sv
// Bounded wait counter for the multiply/divide handshake. Counts cycles
// while enable is high; expired flags the last permitted waiting cycle so the
// controller can leave on the same edge that would reach LIMIT.
module ack_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_r;

  // Wait-cycle counter: reset and clear dominate, otherwise count while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/series_term_ctrl.sv
// Sequencer for the iterative series datapath (term register, sum
// accumulator, shared multiply/divide unit). After a start it presets term
// and sum, then runs N_TERMS request/load/accumulate iterations.
// Optional feature macro: SERIES_EARLY_EXIT_EN -- stop early once the term
// register reads zero after its load.
module series_term_ctrl
  import series_pkg::*;
#(
  parameter int N_TERMS     = 8,
  parameter int IDX_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              custom_reset,
  input  logic              start,
  input  logic [15:0]       term_in,
  input  logic              mul_ack,
  output logic              term_reset,
  output logic              term_load,
  output logic              sum_reset,
  output logic              sum_load,
  output logic              mul_req,
  output logic [IDX_W-1:0]  iter,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Reject parameter sets where the iteration index could wrap.
  if (N_TERMS < 1 || N_TERMS > 255 || N_TERMS > (2**IDX_W) - 1) begin : g_bad_n_terms
    $error("series_term_ctrl: N_TERMS out of range for IDX_W");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("series_term_ctrl: ACK_TIMEOUT must be at least 1");
  end
  if (ONE_Q != (DATA_W'(1) << FRAC_BITS)) begin : g_bad_one_q
    $error("series_term_ctrl: ONE_Q does not match FRAC_BITS");
  end

  state_t state_r;
  state_t state_next_s;

  logic ack_wait_s;
  logic ack_clear_s;
  logic ack_expired_s;
  logic last_iter_s;
  logic early_exit_s;

  assign ack_wait_s  = (state_r == MUL_REQ) && !mul_ack;
  assign ack_clear_s = (state_r != MUL_REQ) || mul_ack;
  assign last_iter_s = (iter == IDX_W'(N_TERMS));

`ifdef SERIES_EARLY_EXIT_EN
  assign early_exit_s = is_zero_q(term_in);
`else
  logic unused_term_in;
  assign unused_term_in = ^term_in;
  assign early_exit_s   = 1'b0;
`endif

  ack_timeout_cnt #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timeout (
    .clk     (clk),
    .rst     (custom_reset),
    .clear   (ack_clear_s),
    .enable  (ack_wait_s),
    .expired (ack_expired_s)
  );

  // Next-state decode for the sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = INIT;
        else       state_next_s = IDLE;
      end
      INIT: state_next_s = MUL_REQ;
      MUL_REQ: begin
        if (mul_ack)            state_next_s = LOAD_TERM;
        else if (ack_expired_s) state_next_s = DONE;
        else                    state_next_s = MUL_REQ;
      end
      LOAD_TERM: state_next_s = ACCUM;
      ACCUM: begin
        if (last_iter_s || early_exit_s) state_next_s = DONE;
        else                             state_next_s = MUL_REQ;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus strobes registered from the state being entered, so
  // each output is flop-driven yet aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (custom_reset) begin
      state_r    <= IDLE;
      term_reset <= 1'b0;
      sum_reset  <= 1'b0;
      mul_req    <= 1'b0;
      term_load  <= 1'b0;
      sum_load   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      term_reset <= (state_next_s == INIT);
      sum_reset  <= (state_next_s == INIT);
      mul_req    <= (state_next_s == MUL_REQ);
      term_load  <= (state_next_s == LOAD_TERM);
      sum_load   <= (state_next_s == ACCUM);
      done       <= (state_next_s == DONE);
      busy       <= (state_next_s != IDLE);
    end
  end

  // Iteration index: 1 after INIT, +1 per continued iteration, held otherwise.
  always_ff @(posedge clk) begin
    if (custom_reset) begin
      iter <= {IDX_W{1'b0}};
    end else if (state_r == INIT) begin
      iter <= IDX_W'(1);
    end else if ((state_r == ACCUM) && (state_next_s == MUL_REQ)) begin
      iter <= iter + IDX_W'(1);
    end else begin
      iter <= iter;
    end
  end

  // Sticky timeout flag: cleared by an accepted start, set on ack timeout.
  always_ff @(posedge clk) begin
    if (custom_reset) begin
      error <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      error <= 1'b0;
    end else if ((state_r == MUL_REQ) && !mul_ack && ack_expired_s) begin
      error <= 1'b1;
    end else begin
      error <= error;
    end
  end

endmodule

// File: doc/series_term_ctrl.md
Name: series_term_ctrl

Overview:
- Sequencer for the iterative series datapath: term register, sum accumulator and shared multiply/divide unit.
- On start, presets term (1.0 in Q4.11, 16'h0800) and sum.
- Then runs N_TERMS iterations: request product term·x/n, load term, accumulate.
- Sits between the top-level control (start/done) and the Term/sum registers' load/reset strobes.

Parameters:
N_TERMS, 8, number of iterations (n = 1..N_TERMS); legal 1..255
IDX_W, 8, width of iteration index output
ACK_TIMEOUT, 15, max cycles mul_req may wait for mul_ack before error

Ports:
clk  in  1  system clock, all logic on posedge
custom_reset  in  1  synchronous, active-high reset
start  in  1  begin evaluation; sampled in IDLE only
term_in  in  16  current Term register value (used by early exit)
mul_ack  in  1  multiply/divide unit result valid
term_reset  out  1  one-cycle preset strobe to Term register (loads 16'h0800)
term_load  out  1  one-cycle load strobe to Term register
sum_reset  out  1  one-cycle clear strobe to sum register
sum_load  out  1  one-cycle accumulate strobe to sum register
mul_req  out  1  request to multiply/divide unit; held until ack
iter  out  IDX_W  current divisor n for the mul unit
busy  out  1  high in any state but IDLE
done  out  1  one-cycle completion pulse
error  out  1  sticky timeout flag; cleared on next accepted start or reset

Behaviour:
- Reset (custom_reset=1 at posedge): state=IDLE, iter=0, timeout counter=0, all outputs 0. Overrides everything, including mid-operation; no strobes issued that cycle.
- Strobes (term_reset, term_load, sum_reset, sum_load, done) are Moore outputs decoded from state, high exactly one cycle.
- IDLE: start=1 -> INIT; error cleared.
- INIT: term_reset=1, sum_reset=1, iter<=1 -> MUL_REQ.
- MUL_REQ:
  - mul_req=1, iter stable. Timeout counter increments each cycle mul_ack=0.
  - mul_ack=1 (incl. first cycle) -> LOAD_TERM, counter cleared.
  - Counter reaching ACK_TIMEOUT with no ack -> DONE with error<=1.
- LOAD_TERM: term_load=1 -> ACCUM.
- ACCUM: sum_load=1.
  - iter==N_TERMS -> DONE.
  - Else iter<=iter+1 -> MUL_REQ.
- DONE: done=1, busy=1 -> IDLE. iter holds last value until next INIT.
- Latency: ack in the same cycle as req gives 3 cycles per iteration. done is high in cycle 2+3·N_TERMS after the start edge (N_TERMS=8: cycle 26).
- Boundary conditions:
  - start while busy: ignored.
  - start and custom_reset together: reset wins.
  - mul_ack outside MUL_REQ: ignored.
  - N_TERMS=1: exactly one iteration.
  - iter never wraps (N_TERMS ≤ 2^IDX_W−1, checked at elaboration).

Optional Feature:
- Macro: SERIES_EARLY_EXIT_EN.
- Defined: in ACCUM, if term_in==16'h0000 (term underflowed to zero after its load), go to DONE instead of MUL_REQ. error stays 0.
- Undefined: term_in is unused and all N_TERMS iterations always run.

Decomposition:
- Shared package series_pkg:
  - state enum (IDLE, INIT, MUL_REQ, LOAD_TERM, ACCUM, DONE)
  - FRAC_BITS=11
  - ONE_Q=16'h0800
  - DATA_W=16
- Sub-module ack_timeout_cnt:
  - inputs clear/enable; output expired.
  - Instantiated once for the MUL_REQ wait.

Test Plan:
- N_TERMS=4, mul_ack tied 1, start pulse at cycle 0 -> term_reset/sum_reset cycle 1; term_load cycles 3,6,9,12; iter 1,2,3,4; done cycle 14; error=0.
- N_TERMS=4, mul_ack 3 cycles after each req -> per-iteration 6 cycles; done at cycle 26; mul_req held high 4 cycles each time.
- ACK_TIMEOUT=15, mul_ack held 0 -> mul_req high 15 cycles, then done pulse with error=1; next start clears error.
- custom_reset asserted in LOAD_TERM of iteration 2 -> next cycle all outputs 0, busy=0, no term_load that cycle; a fresh start then runs the full sequence.
- start re-pulsed at cycles 5 and 10 during a run -> ignored; exactly one done.
- With SERIES_EARLY_EXIT_EN, N_TERMS=8, term_in forced 16'h0000 after iteration 3 -> done at cycle 11. Without the macro -> done at cycle 26.
